// File: rtl/tmr_stim_gen_pkg.sv
// Shared types and helpers for the triplicated-lane stimulus generator:
// fault kinds, lane ids, FSM states, LFSR step and the lane-corruption function.
package tmr_pkg;

    typedef enum logic [1:0] {
        STUCK0 = 2'd0,
        STUCK1 = 2'd1,
        INVERT = 2'd2,
        DOUBLE = 2'd3
    } inj_kind_e;

    typedef enum logic [1:0] {
        LANE_A = 2'd0,
        LANE_B = 2'd1,
        LANE_C = 2'd2
    } lane_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2
    } fault_state_e;

    // Feedback taps l[7], l[5], l[4], l[3]
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

    // Returns {c, b, a} after corrupting the fault-free value v
    function automatic logic [2:0] apply_fault(input logic v, input lane_e lane,
                                               input inj_kind_e kind);
        logic [2:0] base;
        logic [2:0] sel;
        logic [2:0] sel_next;
        logic [2:0] r;
        base = {3{v}};
        case (lane)
            LANE_B:  sel = 3'b010;
            LANE_C:  sel = 3'b100;
            default: sel = 3'b001;
        endcase
        sel_next = {sel[1], sel[0], sel[2]};
        case (kind)
            STUCK0:  r = base & ~sel;
            STUCK1:  r = base | sel;
            INVERT:  r = base ^ sel;
            DOUBLE:  r = base ^ (sel | sel_next);
            default: r = base;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmr_stim_gen_if.sv
// Fault-injection request/acknowledge bundle between the test controller
// (master) and the stimulus generator (slave).
interface tmr_stim_gen_if
    import tmr_pkg::*;
#(
    parameter int LEN_W = 8
);
    logic             inj_req;
    logic             inj_ack;
    logic [1:0]       inj_lane;
    logic [1:0]       inj_kind;
    logic [LEN_W-1:0] inj_len;
    logic             inj_abort;

    modport master (
        output inj_req,
        output inj_lane,
        output inj_kind,
        output inj_len,
        output inj_abort,
        input  inj_ack
    );

    modport slave (
        input  inj_req,
        input  inj_lane,
        input  inj_kind,
        input  inj_len,
        input  inj_abort,
        output inj_ack
    );
endinterface

// File: rtl/tmr_stim_gen_lfsr8.sv
// 8-bit Fibonacci LFSR that advances one position per asserted adv cycle.
module lfsr8
    import tmr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    input  logic [7:0] seed,
    output logic [7:0] q
);
    logic [7:0] q_d;
    logic [7:0] q_q;

    // Next-state selection: shift on advance, otherwise hold
    always_comb begin
        if (adv) begin
            q_d = lfsr_next(q_q);
        end else begin
            q_d = q_q;
        end
    end

    // LFSR state register, seeded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/tmr_stim_gen.sv
// Pseudo-random golden stream driven on three redundant lanes, with a
// request/ack fault injector that corrupts lanes for a bounded number of steps.
module tmr_stim_gen
    import tmr_pkg::*;
#(
    parameter int         DIV   = 4,
    parameter logic [7:0] SEED  = 8'hA5,
    parameter int         LEN_W = 8
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    tmr_stim_gen_if.slave  inj,
    output logic           a,
    output logic           b,
    output logic           c,
    output logic           golden,
    output logic           step,
    output logic           fault_active
);
    localparam int         PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [7:0] SEED_SAFE  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_ARM      = ARM;
    localparam logic [1:0] S_ACTIVE   = ACTIVE;

    logic [PW-1:0]    cnt_d, cnt_q;
    logic             strobe_s;
    logic [7:0]       lfsr_s;
    logic [7:0]       lfsr_nxt_s;
    logic [1:0]       state_d, state_q;
    lane_e            lane_d, lane_q;
    inj_kind_e        kind_d, kind_q;
    logic [LEN_W-1:0] len_d, len_q;
    logic [LEN_W-1:0] left_d, left_q;
    logic             ack_d, ack_q;
    logic [2:0]       lanes_d, lanes_q;
    logic             golden_d, golden_q;
    logic             step_d, step_q;
    logic             fa_d, fa_q;
    logic             abort_s;
    logic             faulted_s;

    // Prescaler: step strobe on the last count of each DIV-cycle window
    always_comb begin
        strobe_s = en && (cnt_q == PW'(DIV - 1));
        if (!en) begin
            cnt_d = cnt_q;
        end else if (strobe_s) begin
            cnt_d = {PW{1'b0}};
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (strobe_s),
        .seed  (SEED_SAFE),
        .q     (lfsr_s)
    );

    assign lfsr_nxt_s = lfsr_next(lfsr_s);
    assign abort_s    = inj.inj_abort && (state_q != S_IDLE);

    // Fault FSM; abort outranks both a step and a new request
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        kind_d    = kind_q;
        len_d     = len_q;
        left_d    = left_q;
        ack_d     = 1'b0;
        faulted_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (inj.inj_req && !inj.inj_abort) begin
                    ack_d   = 1'b1;
                    state_d = S_ARM;
                    lane_d  = (inj.inj_lane == 2'd3) ? LANE_A : lane_e'(inj.inj_lane);
                    kind_d  = inj_kind_e'(inj.inj_kind);
                    len_d   = (inj.inj_len == {LEN_W{1'b0}}) ? LEN_W'(1) : inj.inj_len;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                if (abort_s) begin
                    state_d = S_IDLE;
                end else if (strobe_s) begin
                    state_d   = S_ACTIVE;
                    left_d    = len_q - LEN_W'(1);
                    faulted_s = 1'b1;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_ACTIVE: begin
                if (abort_s) begin
                    state_d = S_IDLE;
                end else if (strobe_s && (left_q == {LEN_W{1'b0}})) begin
                    state_d = S_IDLE;
                end else if (strobe_s) begin
                    left_d    = left_q - LEN_W'(1);
                    faulted_s = 1'b1;
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Lane/golden update at step edges, plus immediate resync on abort
    always_comb begin
        golden_d = golden_q;
        lanes_d  = lanes_q;
        step_d   = strobe_s;
        fa_d     = (state_d == S_ACTIVE);
        if (strobe_s) begin
            golden_d = lfsr_nxt_s[0];
            if (faulted_s) begin
                lanes_d = apply_fault(lfsr_nxt_s[0], lane_q, kind_q);
            end else begin
                lanes_d = {3{lfsr_nxt_s[0]}};
            end
        end else if (abort_s) begin
            lanes_d = {3{golden_q}};
        end else begin
            lanes_d = lanes_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= {PW{1'b0}};
            state_q  <= S_IDLE;
            lane_q   <= LANE_A;
            kind_q   <= STUCK0;
            len_q    <= {LEN_W{1'b0}};
            left_q   <= {LEN_W{1'b0}};
            ack_q    <= 1'b0;
            lanes_q  <= 3'b000;
            golden_q <= 1'b0;
            step_q   <= 1'b0;
            fa_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            lane_q   <= lane_d;
            kind_q   <= kind_d;
            len_q    <= len_d;
            left_q   <= left_d;
            ack_q    <= ack_d;
            lanes_q  <= lanes_d;
            golden_q <= golden_d;
            step_q   <= step_d;
            fa_q     <= fa_d;
        end
    end

    assign inj.inj_ack   = ack_q;
    assign a             = lanes_q[0];
    assign b             = lanes_q[1];
    assign c             = lanes_q[2];
    assign golden        = golden_q;
    assign step          = step_q;
    assign fault_active  = fa_q;
endmodule

// File: doc/tmr_stim_gen.md
Name: tmr_stim_gen

Overview:
- Transmit end of the triplicated-signal path: generates a pseudo-random golden bit stream and drives it on three redundant lanes a/b/c into the majority voter.
- Lanes can be corrupted for a controlled number of steps by a fault-injection request, so the voter's masking (single fault) and failure (double fault) behaviour can be exercised on hardware.
- Sits in the system block region that feeds the voter.
- Outputs a golden reference bit for on-chip comparison.

Parameters:
- DIV, 4: clock cycles per pattern step (≥1); prescaler width is $clog2(DIV), minimum 1.
- SEED, 8'hA5: LFSR reset value; 8'h00 is illegal and is replaced by 8'h01.
- LEN_W, 8: width of the fault-length field.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  step enable; 0 freezes prescaler, LFSR and fault FSM
- inj_req  input  1  fault request, held until inj_ack
- inj_ack  output  1  one-cycle accept pulse
- inj_lane  input  2  target lane: 0=a, 1=b, 2=c; 3 is treated as 0
- inj_kind  input  2  0=stuck0, 1=stuck1, 2=invert, 3=double invert (lane and (lane+1) mod 3)
- inj_len  input  LEN_W  fault duration in steps; 0 is treated as 1
- inj_abort  input  1  terminate pending or active fault
- a, b, c  output  1 each  redundant lanes
- golden  output  1  fault-free bit
- step  output  1  one-cycle pulse on each pattern step
- fault_active  output  1  high while the FSM is in ACTIVE

Behaviour:
- Reset, asynchronous:
  - a=b=c=golden=0; step=0; inj_ack=0; fault_active=0
  - lfsr=SEED; prescaler=0; FSM=IDLE
- Prescaler:
  - With en=1, counts 0..DIV-1 and wraps to 0.
  - The internal step strobe fires in the cycle where the count is DIV-1.
  - The step output is the registered strobe, coincident with the lane update.
- LFSR:
  - 8-bit Fibonacci LFSR; fb = l[7]^l[5]^l[4]^l[3]; next = {l[6:0], fb}.
  - Advances only on a step strobe.
- Output update, on the step-strobe edge only:
  - golden <= next[0].
  - Each lane <= next[0], unless that lane is faulted in the resulting FSM state.
  - Lanes change only at step edges, with one exception: abort resync (below).
- Fault FSM, states IDLE, ARM, ACTIVE:
  - IDLE: when inj_req=1 and inj_abort=0, pulse inj_ack for 1 cycle, latch lane/kind/len, go to ARM.
  - ARM: at the next step edge, go to ACTIVE, load cnt=len-1, and corrupt that step's lanes.
  - ACTIVE: at each step edge, if cnt==0 go to IDLE and emit clean lanes for that step; otherwise decrement cnt and emit faulted lanes.
  - Net effect: exactly max(inj_len,1) consecutive faulted steps.
  - inj_req is ignored outside IDLE; inj_ack stays 0.
- Fault kinds, applied to lane value v:
  - stuck0: 0
  - stuck1: 1
  - invert: ~v
  - double: ~v on two lanes
- inj_abort:
  - In ARM or ACTIVE: go to IDLE on the next edge, and resync a=b=c=golden on that same edge, even without a step.
  - In IDLE: no effect. Abort wins over a simultaneous inj_req, so no ack is given.
- en=0: all state holds, no step pulses. inj_req is still accepted into ARM; inj_abort still acts.
- Reset mid-fault: lanes return to 0 and the FSM to IDLE immediately; no ack is pending.
- Invariant: in IDLE, a==b==c==golden.

Decomposition:
- tmr_pkg:
  - inj_kind_e: STUCK0, STUCK1, INVERT, DOUBLE
  - lane_e: LANE_A, LANE_B, LANE_C
  - fault_state_e: IDLE, ARM, ACTIVE
  - LFSR taps constant
  - function apply_fault(v, lane, kind) returning the 3-bit lane vector
- Sub-module lfsr8: clk, rst_n, adv, seed → q. Instantiated once.

Test Plan:
1. Reset, SEED=A5, DIV=4, en=1, no faults → step pulses every 4 cycles; golden sequence after steps 1,2: lfsr 4A→0, 95→1; a=b=c=golden throughout.
2. inj_req with lane=1, kind=stuck1, len=3 → inj_ack 1 cycle; next step: b=1 while a=c=golden for 3 steps, fault_active high for those steps; 4th step clean.
3. lane=2, kind=double, len=2 → c and a inverted for 2 steps while b=golden, so voter output ≠ golden; lanes clean afterward.
4. Abort during ACTIVE with len=10 after 2 steps → next cycle FSM=IDLE, a=b=c=golden without waiting for a step, fault_active=0.
5. inj_req and inj_abort asserted together in IDLE → no inj_ack, state stays IDLE; inj_len=0 request → exactly 1 faulted step.
6. en=0 for 20 cycles mid-ARM → no step, lanes and LFSR frozen; en=1 → fault starts at the first subsequent step.
